// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded fields and operands for EX, with stall/flush and a saturating bubble counter.
// Optional ID_EX_WB_BYPASS_EN: bypass a same-cycle writeback into captured and held operands.
module id_ex_stage_reg #(
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic [31:0]       ReadData1,
    input  logic [31:0]       ReadData2,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    input  logic [4:0]        RdIn,
    input  logic [31:0]       ImmIn,
    input  logic [31:0]       PCPlus4In,
    input  logic [CTRL_W-1:0] CtrlIn,
    input  logic              RegWrite,
    input  logic [4:0]        WriteRegister,
    input  logic [31:0]       WriteData,
    output logic              ExValid,
    output logic [CTRL_W-1:0] ExCtrl,
    output logic [31:0]       ExA,
    output logic [31:0]       ExB,
    output logic [31:0]       ExImm,
    output logic [31:0]       ExPCPlus4,
    output logic [4:0]        ExRs,
    output logic [4:0]        ExRt,
    output logic [4:0]        ExRd,
    output logic [CNT_W-1:0]  BubbleCount
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       a;
        logic [31:0]       b;
        logic [31:0]       imm;
        logic [31:0]       pc4;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bubble;

`ifdef ID_EX_WB_BYPASS_EN
    logic wb_live;
    assign wb_live = RegWrite && (WriteRegister != 5'd0);
`else
    logic wb_unused;
    assign wb_unused = ^{RegWrite, WriteRegister, WriteData};
`endif

    always_comb begin
        ex_d   = ex_q;
        bubble = 1'b0;
        if (Flush) begin
            ex_d   = '0;
            bubble = 1'b1;
        end else if (Stall) begin
`ifdef ID_EX_WB_BYPASS_EN
            // Held operands must not miss a writeback that lands while EX is frozen
            if (ex_q.valid && wb_live && WriteRegister == ex_q.rs) ex_d.a = WriteData;
            if (ex_q.valid && wb_live && WriteRegister == ex_q.rt) ex_d.b = WriteData;
`endif
        end else begin
            ex_d.valid = InValid;
            ex_d.ctrl  = InValid ? CtrlIn : '0;
            ex_d.a     = ReadData1;
            ex_d.b     = ReadData2;
            ex_d.imm   = ImmIn;
            ex_d.pc4   = PCPlus4In;
            ex_d.rs    = ReadRegister1;
            ex_d.rt    = ReadRegister2;
            ex_d.rd    = RdIn;
            bubble     = !InValid;
`ifdef ID_EX_WB_BYPASS_EN
            if (wb_live && WriteRegister == ReadRegister1) ex_d.a = WriteData;
            if (wb_live && WriteRegister == ReadRegister2) ex_d.b = WriteData;
`endif
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bubble && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ExValid     = ex_q.valid;
    assign ExCtrl      = ex_q.ctrl;
    assign ExA         = ex_q.a;
    assign ExB         = ex_q.b;
    assign ExImm       = ex_q.imm;
    assign ExPCPlus4   = ex_q.pc4;
    assign ExRs        = ex_q.rs;
    assign ExRt        = ex_q.rt;
    assign ExRd        = ex_q.rd;
    assign BubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized self-checking bench for id_ex_stage_reg against a cycle-level behavioural model.
module tb_id_ex_stage_reg;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              Clk = 1'b0;
    logic              Reset, Stall, Flush, InValid, RegWrite;
    logic [31:0]       ReadData1, ReadData2, ImmIn, PCPlus4In, WriteData;
    logic [4:0]        ReadRegister1, ReadRegister2, RdIn, WriteRegister;
    logic [CTRL_W-1:0] CtrlIn;
    logic              ExValid;
    logic [CTRL_W-1:0] ExCtrl;
    logic [31:0]       ExA, ExB, ExImm, ExPCPlus4;
    logic [4:0]        ExRs, ExRt, ExRd;
    logic [CNT_W-1:0]  BubbleCount;

    id_ex_stage_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .RdIn(RdIn), .ImmIn(ImmIn), .PCPlus4In(PCPlus4In), .CtrlIn(CtrlIn),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ExValid(ExValid), .ExCtrl(ExCtrl), .ExA(ExA), .ExB(ExB), .ExImm(ExImm),
        .ExPCPlus4(ExPCPlus4), .ExRs(ExRs), .ExRt(ExRt), .ExRd(ExRd),
        .BubbleCount(BubbleCount)
    );

    always #5 Clk = ~Clk;

`ifdef ID_EX_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // reference state
    bit        m_valid;
    int        m_ctrl, m_cnt;
    bit [31:0] m_a, m_b, m_imm, m_pc;
    int        m_rs, m_rt, m_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit wb_hits(input int idx);
        return BYP && RegWrite && WriteRegister != 0 && int'(WriteRegister) == idx;
    endfunction

    task automatic model_edge();
        if (Reset) begin
            m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_cnt = 0;
        end else if (Flush) begin
            m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc = 0;
            m_rs = 0; m_rt = 0; m_rd = 0;
            if (m_cnt < CMAX) m_cnt++;
        end else if (Stall) begin
            if (m_valid && wb_hits(m_rs)) m_a = WriteData;
            if (m_valid && wb_hits(m_rt)) m_b = WriteData;
        end else begin
            m_valid = InValid;
            m_ctrl  = InValid ? int'(CtrlIn) : 0;
            m_a     = wb_hits(int'(ReadRegister1)) ? WriteData : ReadData1;
            m_b     = wb_hits(int'(ReadRegister2)) ? WriteData : ReadData2;
            m_imm   = ImmIn; m_pc = PCPlus4In;
            m_rs = ReadRegister1; m_rt = ReadRegister2; m_rd = RdIn;
            if (!InValid && m_cnt < CMAX) m_cnt++;
        end
    endtask

    task automatic check_all();
        chk("valid", ExValid, m_valid);
        chk("ctrl", ExCtrl, m_ctrl);
        chk("a", ExA, m_a);
        chk("b", ExB, m_b);
        chk("imm", ExImm, m_imm);
        chk("pc4", ExPCPlus4, m_pc);
        chk("rs", ExRs, m_rs);
        chk("rt", ExRt, m_rt);
        chk("rd", ExRd, m_rd);
        chk("cnt", BubbleCount, m_cnt);
        chk("ctrl_bubble", (ExValid == 0 && ExCtrl != 0), 0);
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        Reset = 0; Stall = 0; Flush = 0; InValid = 0; RegWrite = 0;
        ReadData1 = 0; ReadData2 = 0; ImmIn = 0; PCPlus4In = 0; WriteData = 0;
        ReadRegister1 = 0; ReadRegister2 = 0; RdIn = 0; WriteRegister = 0; CtrlIn = 0;
    endtask

    initial begin
        idle();
        m_cnt = 0;
        // reset, then first load
        Reset = 1;
        repeat (2) begin
            step();
            chk("rst_valid", ExValid, 0);
            chk("rst_cnt", BubbleCount, 0);
        end
        Reset = 0; InValid = 1; ReadRegister1 = 8; ReadData1 = 32'h11; CtrlIn = 12'h0A5;
        step();
        chk("load_valid", ExValid, 1);
        chk("load_rs", ExRs, 8);
        chk("load_a", ExA, 32'h11);
        chk("load_ctrl", ExCtrl, 12'h0A5);

        // stall hold
        ReadData1 = 5; step();
        Stall = 1; ReadData1 = 9;
        repeat (3) begin step(); chk("stall_a", ExA, 5); end
        Stall = 0; step();
        chk("unstall_a", ExA, 9);

        // flush beats stall, then a non-valid load counts too
        Reset = 1; step(); Reset = 0;
        Stall = 1; Flush = 1; InValid = 1; CtrlIn = 12'hFFF;
        step();
        chk("fl_valid", ExValid, 0);
        chk("fl_ctrl", ExCtrl, 0);
        chk("fl_cnt", BubbleCount, 1);
        Stall = 0; Flush = 0; InValid = 0;
        step();
        chk("bub_cnt", BubbleCount, 2);

        // same-cycle writeback on load
        InValid = 1; ReadRegister1 = 9; ReadRegister2 = 9; ReadData1 = 1; ReadData2 = 1;
        RegWrite = 1; WriteRegister = 9; WriteData = 32'hDEAD;
        step();
        chk("byp_a", ExA, BYP ? 32'hDEAD : 32'h1);
        chk("byp_b", ExB, BYP ? 32'hDEAD : 32'h1);
        WriteRegister = 0;
        step();
        chk("byp0_a", ExA, 32'h1);
        chk("byp0_b", ExB, 32'h1);

        // refresh of held operand
        RegWrite = 0; ReadRegister2 = 10; ReadData2 = 3; InValid = 1;
        step();
        Stall = 1; RegWrite = 1; WriteRegister = 10; WriteData = 32'h77;
        step();
        chk("refresh_b", ExB, BYP ? 32'h77 : 32'h3);
        Stall = 0; RegWrite = 0; InValid = 0;
        step();
        Stall = 1; RegWrite = 1;
        step();
        chk("norefresh_b", ExB, 32'h3);
        Stall = 0; RegWrite = 0;

        // saturation
        Flush = 1;
        repeat (20) step();
        chk("sat_cnt", BubbleCount, 15);
        step();
        chk("sat_hold", BubbleCount, 15);
        Flush = 0; Reset = 1;
        step();
        chk("sat_rst", BubbleCount, 0);
        Reset = 0;

        // random traffic with small register indices to provoke hazards
        for (int i = 0; i < 500; i++) begin
            Reset         = ($urandom_range(0, 49) == 0);
            Flush         = ($urandom_range(0, 7) == 0);
            Stall         = ($urandom_range(0, 3) == 0);
            InValid       = ($urandom_range(0, 3) != 0);
            RegWrite      = $urandom_range(0, 1);
            WriteRegister = 5'($urandom_range(0, 3));
            WriteData     = $urandom;
            ReadRegister1 = 5'($urandom_range(0, 3));
            ReadRegister2 = 5'($urandom_range(0, 3));
            RdIn          = 5'($urandom);
            ReadData1     = $urandom;
            ReadData2     = $urandom;
            ImmIn         = $urandom;
            PCPlus4In     = $urandom;
            CtrlIn        = CTRL_W'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the 5-stage MIPS datapath. It sits directly downstream of the register file: it captures the two register-file read ports, the decoded instruction fields and the control word at the end of ID, and presents them to EX one cycle later. It supports stall (hold) and flush (bubble insertion) and keeps a saturating bubble counter. Optionally, it bypasses a same-cycle writeback into the captured operands.

## Interface
Parameters:
- CTRL_W, 12, width of the opaque control word passed from decode to EX
- CNT_W, 16, width of the bubble counter

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high; sampled on rising edge of Clk
- Stall  input  1  hold all registered outputs this cycle
- Flush  input  1  load a bubble this cycle
- InValid  input  1  ID stage holds a real instruction
- ReadData1  input  32  register-file port 1 data (rs)
- ReadData2  input  32  register-file port 2 data (rt)
- ReadRegister1  input  5  rs index driven to the register file
- ReadRegister2  input  5  rt index driven to the register file
- RdIn  input  5  rd field
- ImmIn  input  32  sign/zero-extended immediate
- PCPlus4In  input  32  PC+4 of the ID instruction
- CtrlIn  input  CTRL_W  decoded control word
- RegWrite  input  1  writeback enable, the same net that drives the register file
- WriteRegister  input  5  writeback index
- WriteData  input  32  writeback data
- ExValid, ExCtrl[CTRL_W], ExA[32], ExB[32], ExImm[32], ExPCPlus4[32], ExRs[5], ExRt[5], ExRd[5]  output  registered EX-stage fields
- BubbleCount  output  CNT_W  number of bubbles loaded since reset, saturating

## Operation
Each rising edge applies exactly one action, in this priority order:
- Reset: every output is set to 0, including ExValid, ExCtrl, all data fields and BubbleCount.
- Flush (overrides Stall): ExValid=0, ExCtrl=0, all data and index fields=0. BubbleCount increments unless it is already all-ones.
- Stall without Flush: all fields hold. The held-operand refresh rule below applies. BubbleCount holds.
- Load (neither Stall nor Flush):
  - ExValid=InValid; all other fields take their In/ReadData/ReadRegister inputs.
  - If InValid=0, ExCtrl is forced to 0 and the event counts as a bubble (BubbleCount increments, saturating).
- ExCtrl is never nonzero while ExValid=0.
- Index 0 is never a bypass or refresh target, regardless of RegWrite.
- The block performs no arithmetic other than the counter. Operands pass through unmodified at 32 bits.

## Timing
- Latency is 1 cycle: an ID instruction present at edge N is visible on Ex* outputs after edge N.
- Stall and Flush are level inputs sampled at the edge. Asserting both is legal; Flush wins.
- The register file writes on the rising edge and reads combinationally. A writeback in the same cycle as the ID read is therefore not yet in ReadData1/2. Handling of this case depends on the macro (see Configuration).
- Reset asserted mid-stall or mid-flush clears everything on that edge. The first load occurs on the first edge with Reset=0.
- BubbleCount saturates at 2^CNT_W-1 and does not wrap.

## Configuration
- Macro: ID_EX_WB_BYPASS_EN.
- Defined, load path:
  - When loading, if RegWrite=1, WriteRegister!=0 and WriteRegister==ReadRegister1, ExA takes WriteData instead of ReadData1.
  - The same rule applies independently for ReadRegister2 / ExB.
  - Both operands may be bypassed in the same cycle.
- Defined, stall path (held-operand refresh):
  - During Stall with ExValid=1, if RegWrite=1, WriteRegister!=0 and WriteRegister==ExRs, ExA updates to WriteData.
  - The same rule applies for ExRt / ExB.
- Not defined: ExA/ExB always take ReadData1/2 on load and hold unchanged under Stall. Same-cycle hazards are left to the forwarding unit.

## Test plan
- Reset then load: Reset=1 for 2 cycles, then InValid=1, ReadRegister1=8, ReadData1=32'h11, CtrlIn=12'h0A5 -> all outputs 0 during reset; one edge after load ExValid=1, ExRs=8, ExA=32'h11, ExCtrl=12'h0A5.
- Stall hold: load ExA=5, then Stall=1 for 3 cycles while inputs change to ExA source 9 -> outputs stay ExA=5 for all 3 cycles; new values appear 1 cycle after Stall drops.
- Flush priority:
  - Stall=1 and Flush=1 together with InValid=1 -> ExValid=0, ExCtrl=0, BubbleCount=1.
  - Next edge with InValid=0 -> BubbleCount=2.
- Bypass (macro defined): ReadRegister1=ReadRegister2=9, ReadData=32'h1, RegWrite=1, WriteRegister=9, WriteData=32'hDEAD -> ExA=ExB=32'hDEAD. Repeat with WriteRegister=0 -> ExA=ExB=32'h1. Without the macro -> 32'h1 in both cases.
- Refresh (macro defined): ExValid=1, ExRt=10, ExB=3; Stall=1 while WB writes reg 10 with 32'h77 -> ExB=32'h77. With ExValid=0 -> ExB unchanged.
- Counter saturation: CNT_W=4, 20 consecutive flushes -> BubbleCount=15 and holds; Reset -> BubbleCount=0.
